// File: rtl/alu_operand_loader.sv
// Board-level entry path for the lab9 ALU: loads A, B and opcode from a switch bank on debounced presses.
// Define ALU_LOADER_CANCEL_EN to add a debounced cancel button that abandons a partial entry.

module alu_operand_loader_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic rstin,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q, deb_q, prev_q;
  logic [CW-1:0] cnt_q;

  // Debounced level follows the synced level only after it has differed for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clock or posedge rstin) begin
    if (rstin) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= deb_q;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press = deb_q & ~prev_q;
endmodule

module alu_operand_loader #(
  parameter int WIDTH           = 6,
  parameter int OPW             = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             rstin,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             btn,
  input  logic             btn_cancel,
  output logic [WIDTH-1:0] ain,
  output logic [WIDTH-1:0] bin,
  output logic [OPW-1:0]   instin,
  output logic             enin,
  output logic             sw,
  output logic [2:0]       stage,
  output logic [7:0]       issue_count
);
  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_OP    = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] ain_q, bin_q;
  logic [OPW-1:0]   instin_q;
  logic             enin_q, sw_q;
  logic [7:0]       issue_count_q;
  logic             press, cancel;

  alu_operand_loader_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clock (clock),
    .rstin (rstin),
    .raw   (btn),
    .press (press)
  );

`ifdef ALU_LOADER_CANCEL_EN
  alu_operand_loader_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel_db (
    .clock (clock),
    .rstin (rstin),
    .raw   (btn_cancel),
    .press (cancel)
  );
`else
  logic unused_btn_cancel;
  assign unused_btn_cancel = btn_cancel;
  assign cancel = 1'b0;
`endif

  // Cancel is checked before press in every state that honours it, so it wins on a shared edge.
  always_ff @(posedge clock or posedge rstin) begin
    if (rstin) begin
      state_q       <= S_A;
      ain_q         <= '0;
      bin_q         <= '0;
      instin_q      <= '0;
      enin_q        <= 1'b0;
      sw_q          <= 1'b0;
      issue_count_q <= '0;
    end else begin
      enin_q <= 1'b0;
      case (state_q)
        S_A: begin
          if (press) begin
            ain_q   <= sw_data;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (cancel) begin
            state_q <= S_A;
          end else if (press) begin
            bin_q   <= sw_data;
            state_q <= S_OP;
          end
        end
        S_OP: begin
          if (cancel) begin
            state_q <= S_A;
          end else if (press) begin
            instin_q <= sw_data[OPW-1:0];
            enin_q   <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          issue_count_q <= issue_count_q + 8'd1;
          sw_q          <= 1'b1;
          state_q       <= S_DONE;
        end
        S_DONE: begin
          if (cancel || press) begin
            sw_q    <= 1'b0;
            state_q <= S_A;
          end
        end
        default: begin
          sw_q    <= 1'b0;
          state_q <= S_A;
        end
      endcase
    end
  end

  assign ain         = ain_q;
  assign bin         = bin_q;
  assign instin      = instin_q;
  assign enin        = enin_q;
  assign sw          = sw_q;
  assign stage       = state_q;
  assign issue_count = issue_count_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed-plus-random bench for alu_operand_loader; define ALU_LOADER_CANCEL_EN to cover the cancel button.

module tb_alu_operand_loader;
  logic       clock = 1'b0;
  logic       rstin;
  logic [5:0] sw_data;
  logic       btn, btn_cancel;
  logic [5:0] ain, bin;
  logic [2:0] instin;
  logic       enin, sw;
  logic [2:0] stage;
  logic [7:0] issue_count;

  int errors = 0;
  int checks = 0;
  int enin_seen = 0;

  // Reference model: entry phase 0=A,1=B,2=opcode,3=result shown.
  int         phase = 0;
  logic [5:0] m_a = '0, m_b = '0;
  logic [2:0] m_op = '0;
  logic [7:0] m_cnt = '0;
  int         enin_exp = 0;
  int         issued_total = 0;

  alu_operand_loader dut (
    .clock       (clock),
    .rstin       (rstin),
    .sw_data     (sw_data),
    .btn         (btn),
    .btn_cancel  (btn_cancel),
    .ain         (ain),
    .bin         (bin),
    .instin      (instin),
    .enin        (enin),
    .sw          (sw),
    .stage       (stage),
    .issue_count (issue_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (!rstin && enin) enin_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_press(input logic [5:0] v);
    case (phase)
      0: begin m_a = v; phase = 1; end
      1: begin m_b = v; phase = 2; end
      2: begin m_op = v[2:0]; m_cnt = m_cnt + 8'd1; enin_exp++; issued_total++; phase = 3; end
      default: phase = 0;
    endcase
  endtask

  task automatic model_cancel();
    if (phase != 0) phase = 0;
  endtask

  task automatic model_reset();
    phase = 0; m_a = '0; m_b = '0; m_op = '0; m_cnt = '0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_stage"}, 32'(stage), (phase == 3) ? 32'd4 : 32'(phase));
    check({tag, "_sw"}, 32'(sw), (phase == 3) ? 32'd1 : 32'd0);
    check({tag, "_ain"}, 32'(ain), 32'(m_a));
    check({tag, "_bin"}, 32'(bin), 32'(m_b));
    check({tag, "_instin"}, 32'(instin), 32'(m_op));
    check({tag, "_issue_count"}, 32'(issue_count), 32'(m_cnt));
    check({tag, "_enin_pulses"}, 32'(enin_seen), 32'(enin_exp));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ain"}, 32'(ain), 32'd0);
    check({tag, "_bin"}, 32'(bin), 32'd0);
    check({tag, "_instin"}, 32'(instin), 32'd0);
    check({tag, "_enin"}, 32'(enin), 32'd0);
    check({tag, "_sw"}, 32'(sw), 32'd0);
    check({tag, "_stage"}, 32'(stage), 32'd0);
    check({tag, "_issue_count"}, 32'(issue_count), 32'd0);
  endtask

  // Hold the button well past the debounce window, then release long enough to settle low.
  task automatic do_press(input logic [5:0] v);
    @(posedge clock); #1;
    sw_data = v;
    btn = 1'b1;
    repeat (10) @(posedge clock);
    #1 btn = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    model_press(v);
  endtask

  task automatic do_cancel(input logic with_btn, input logic [5:0] v);
    @(posedge clock); #1;
    sw_data = v;
    btn_cancel = 1'b1;
    btn = with_btn;
    repeat (10) @(posedge clock);
    #1 begin btn_cancel = 1'b0; btn = 1'b0; end
    repeat (10) @(posedge clock);
    #1;
    model_cancel();
  endtask

  initial begin
    int first_at, changes;
    logic [2:0] prev_stage;

    rstin = 1'b1; btn = 1'b0; btn_cancel = 1'b0; sw_data = '0;
    repeat (3) @(posedge clock);
    #1 check_all_zero("reset");
    rstin = 1'b0;

    // Glitch of three cycles must not register.
    @(posedge clock); #1;
    sw_data = 6'd21; btn = 1'b1;
    repeat (3) @(posedge clock);
    #1 btn = 1'b0;
    repeat (15) @(posedge clock);
    #1 check("glitch_stage", 32'(stage), 32'd0);
    check("glitch_ain", 32'(ain), 32'd0);

    // Held press: exactly one transition, on the 7th edge after the first sampling edge.
    @(posedge clock); #1;
    sw_data = 6'd13; btn = 1'b1;
    first_at = 0; changes = 0; prev_stage = stage;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (stage !== prev_stage) begin
        changes++;
        if (first_at == 0) first_at = k;
      end
      prev_stage = stage;
    end
    check("hold_changes", 32'(changes), 32'd1);
    check("hold_edge", 32'(first_at), 32'd8);
    btn = 1'b0;
    repeat (10) @(posedge clock);
    #1 model_press(6'd13);
    check_state("after_a");

    do_press(6'd50);
    do_press(6'd5);
    check_state("full_seq");

    do_press(6'd33);
    check_state("back_to_a");

    do_press(6'd1);
    do_press(6'd2);
    do_press(6'b111010);
    check("mask_instin", 32'(instin), 32'd2);
    check_state("mask_seq");
    do_press(6'd60);
    check_state("mask_return");

    while (issued_total < 256) begin
      do_press(6'($urandom_range(0, 63)));
      do_press(6'($urandom_range(0, 63)));
      do_press(6'($urandom_range(0, 63)));
      check_state("rand_seq");
      do_press(6'($urandom_range(0, 63)));
    end
    check("wrap_issue_count", 32'(issue_count), 32'd0);
    check("wrap_enin_pulses", 32'(enin_seen), 32'd256);

    // Asynchronous reset mid-cycle while in the opcode stage.
    do_press(6'($urandom_range(0, 63)));
    do_press(6'($urandom_range(0, 63)));
    check("pre_reset_stage", 32'(stage), 32'd2);
    @(negedge clock); #1;
    rstin = 1'b1;
    #1 check_all_zero("mid_reset");
    @(posedge clock); #1;
    rstin = 1'b0;
    model_reset();

`ifdef ALU_LOADER_CANCEL_EN
    do_press(6'd7);
    do_cancel(1'b0, 6'd0);
    check_state("cancel_in_b");
    check("cancel_ain", 32'(ain), 32'd7);
    do_press(6'd9);
    do_press(6'd20);
    do_cancel(1'b1, 6'd6);
    check_state("cancel_vs_btn");
    check("cancel_instin", 32'(instin), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
